// File: rtl/noc_input_fifo_cts_if.sv
// Link bundle between one router input FIFO and its environment: the
// upstream router's RTS/CTS handshake, the per-output grants, and the
// head-of-queue status seen by the crossbar.
interface noc_input_fifo_cts_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic                  DRTS;
    logic [DATA_WIDTH-1:0] RX;
    logic                  CTS;
    logic                  read_en_N;
    logic                  read_en_E;
    logic                  read_en_W;
    logic                  read_en_S;
    logic                  read_en_L;
    logic [DATA_WIDTH-1:0] Data_out;
    logic                  empty;
    logic                  full;
    logic [PTR_W:0]        count;

    // Upstream router plus output arbiters
    modport master (
        output DRTS, RX, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        input  CTS, Data_out, empty, full, count
    );

    // The input FIFO itself
    modport slave (
        input  DRTS, RX, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        output CTS, Data_out, empty, full, count
    );
endinterface

// File: rtl/noc_input_fifo_cts.sv
// Router input port: accepts flits over an RTS/CTS handshake into a circular
// buffer and presents the head flit to the crossbar with zero read latency.
// CTS pulses for one cycle per accepted flit and is withheld while full.
module noc_input_fifo_cts #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    noc_input_fifo_cts_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count_q;
    logic [PTR_W:0]        count_nxt;
    logic                  empty_q;
    logic                  full_q;
    logic                  cts_q;
    logic                  any_read;
    logic                  wr_en;
    logic                  rd_en;

    // Accept/pop decisions; full is the registered value, so a same-cycle pop
    // never opens room for a write
    always_comb begin
        any_read  = bus.read_en_N | bus.read_en_E | bus.read_en_W |
                    bus.read_en_S | bus.read_en_L;
        wr_en     = bus.DRTS && !cts_q && !full_q;
        rd_en     = any_read && !empty_q;
        count_nxt = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    // Flit storage; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.RX;
        end
    end

    // Pointers, occupancy flags and the CTS pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            cts_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == FULL_CNT);
            cts_q   <= wr_en;
        end
    end

    assign bus.CTS      = cts_q;
    assign bus.Data_out = empty_q ? '0 : mem[rd_ptr];
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.count    = count_q;
endmodule

// File: tb/tb_noc_input_fifo_cts.sv
// Directed scenarios plus a randomized upstream/arbiter run, checked against
// a queue-based model of the receive FIFO.
module tb_noc_input_fifo_cts;
    localparam int DW = 32;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [DW-1:0] mq[$];
    bit            cts_m = 1'b0;

    noc_input_fifo_cts_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus();

    noc_input_fifo_cts #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] exp_data();
        return (mq.size() != 0) ? mq[0] : '0;
    endfunction

    function automatic logic [2:0] exp_count();
        return 3'(mq.size());
    endfunction

    // One clock: model decides from the current inputs, then both advance
    task automatic cycle();
        bit w, p;
        w = bus.DRTS && !cts_m && (mq.size() < DP);
        p = (bus.read_en_N | bus.read_en_E | bus.read_en_W | bus.read_en_S | bus.read_en_L)
            && (mq.size() != 0);
        @(posedge clk);
        if (p) void'(mq.pop_front());
        if (w) mq.push_back(bus.RX);
        cts_m = w;
        #1;
    endtask

    task automatic clear_inputs();
        bus.DRTS = 0; bus.RX = '0;
        bus.read_en_N = 0; bus.read_en_E = 0; bus.read_en_W = 0;
        bus.read_en_S = 0; bus.read_en_L = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #3;
        mq.delete();
        cts_m = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.CTS !== 1'b0) begin failures++; $display("FAIL rst0_cts got=%0h exp=0", bus.CTS); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL rst0_count got=%0d exp=0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL rst0_empty got=%0h exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL rst0_full got=%0h exp=0", bus.full); end
        checks++; if (bus.Data_out !== 32'h0) begin failures++; $display("FAIL rst0_data got=%h exp=0", bus.Data_out); end
        for (int i = 0; i < 3; i++) begin
            bus.DRTS = 1; bus.RX = 32'hC0DE_0000 + i;
            cycle();
            if (i < 2) begin bus.DRTS = 0; cycle(); end
        end
        checks++; if (bus.count !== 3'd3 || bus.CTS !== 1'b1) begin failures++; $display("FAIL t1_pre got count=%0d cts=%0h exp count=3 cts=1", bus.count, bus.CTS); end
        rst = 1'b1;
        #1;
        checks++; if (bus.CTS !== 1'b0) begin failures++; $display("FAIL t1_cts got=%0h exp=0", bus.CTS); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL t1_count got=%0d exp=0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL t1_empty got=%0h exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL t1_full got=%0h exp=0", bus.full); end
        checks++; if (bus.Data_out !== 32'h0) begin failures++; $display("FAIL t1_data got=%h exp=0", bus.Data_out); end
        bus.DRTS = 0;
        apply_reset();
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL t1_after got=%0d exp=0", bus.count); end
    endtask

    task automatic test_single();
        bus.DRTS = 1; bus.RX = 32'hA5A5_0001;
        cycle();
        checks++; if (bus.CTS !== 1'b1) begin failures++; $display("FAIL t2_cts1 got=%0h exp=1", bus.CTS); end
        checks++; if (bus.count !== 3'd1) begin failures++; $display("FAIL t2_count got=%0d exp=1", bus.count); end
        checks++; if (bus.Data_out !== 32'hA5A5_0001) begin failures++; $display("FAIL t2_data got=%h exp=a5a50001", bus.Data_out); end
        cycle();
        checks++; if (bus.CTS !== 1'b0) begin failures++; $display("FAIL t2_cts2 got=%0h exp=0", bus.CTS); end
        checks++; if (bus.count !== 3'd1) begin failures++; $display("FAIL t2_no2nd got=%0d exp=1", bus.count); end
        bus.DRTS = 0;
        bus.read_en_L = 1; cycle(); bus.read_en_L = 0;
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL t2_drain got=%0h exp=1", bus.empty); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            bus.DRTS = 1; bus.RX = 32'(i);
            cycle();
            bus.DRTS = 0;
            cycle();
        end
        checks++; if (bus.full !== 1'b1 || bus.count !== 3'd4) begin failures++; $display("FAIL t3_full got full=%0h count=%0d exp full=1 count=4", bus.full, bus.count); end
        bus.DRTS = 1; bus.RX = 32'h5;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (bus.CTS !== 1'b0 || bus.count !== 3'd4) begin failures++; $display("FAIL t3_hold got cts=%0h count=%0d exp cts=0 count=4", bus.CTS, bus.count); end
        end
        checks++; if (bus.Data_out !== 32'h1) begin failures++; $display("FAIL t3_head got=%h exp=1", bus.Data_out); end
        bus.read_en_E = 1; cycle(); bus.read_en_E = 0;
        checks++; if (bus.full !== 1'b0 || bus.CTS !== 1'b0 || bus.count !== 3'd3) begin failures++; $display("FAIL t3_pop got full=%0h cts=%0h count=%0d exp 0 0 3", bus.full, bus.CTS, bus.count); end
        cycle();
        checks++; if (bus.CTS !== 1'b1 || bus.count !== 3'd4) begin failures++; $display("FAIL t3_refill got cts=%0h count=%0d exp cts=1 count=4", bus.CTS, bus.count); end
        bus.DRTS = 0;
        cycle();
        for (int k = 2; k <= 5; k++) begin
            checks++; if (bus.Data_out !== 32'(k)) begin failures++; $display("FAIL t3_order got=%h exp=%h", bus.Data_out, 32'(k)); end
            bus.read_en_E = 1; cycle(); bus.read_en_E = 0;
        end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL t3_empty got=%0h exp=1", bus.empty); end
    endtask

    task automatic test_wrap_order();
        logic [DW-1:0] seen[$];
        for (int i = 0; i < 10; i++) begin
            bus.DRTS = 1; bus.RX = 32'h10 + i;
            cycle();
            bus.DRTS = 0;
            checks++; if (bus.CTS !== 1'b1) begin failures++; $display("FAIL t4_cts got=%0h exp=1 flit=%0d", bus.CTS, i); end
            if (i >= 1 && (i % 3) != 0) begin
                seen.push_back(bus.Data_out);
                bus.read_en_L = 1;
            end
            cycle();
            bus.read_en_L = 0;
        end
        for (int i = 0; i < 8 && bus.empty !== 1'b1; i++) begin
            seen.push_back(bus.Data_out);
            bus.read_en_L = 1; cycle(); bus.read_en_L = 0;
        end
        checks++; if (seen.size() != 10) begin failures++; $display("FAIL t4_len got=%0d exp=10", seen.size()); end
        for (int i = 0; i < seen.size() && i < 10; i++) begin
            checks++; if (seen[i] !== 32'h10 + i) begin failures++; $display("FAIL t4_seq got=%h exp=%h idx=%0d", seen[i], 32'h10 + i, i); end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 2; i++) begin
            bus.DRTS = 1; bus.RX = 32'h50 + i; cycle(); bus.DRTS = 0; cycle();
        end
        checks++; if (bus.count !== 3'd2 || bus.Data_out !== 32'h50) begin failures++; $display("FAIL t5_pre got count=%0d data=%h exp 2 50", bus.count, bus.Data_out); end
        bus.DRTS = 1; bus.RX = 32'h52; bus.read_en_W = 1;
        cycle();
        bus.DRTS = 0; bus.read_en_W = 0;
        checks++; if (bus.count !== 3'd2) begin failures++; $display("FAIL t5_count got=%0d exp=2", bus.count); end
        checks++; if (bus.CTS !== 1'b1) begin failures++; $display("FAIL t5_cts got=%0h exp=1", bus.CTS); end
        checks++; if (bus.Data_out !== 32'h51) begin failures++; $display("FAIL t5_head got=%h exp=51", bus.Data_out); end
        bus.read_en_W = 1; cycle();
        checks++; if (bus.Data_out !== 32'h52) begin failures++; $display("FAIL t5_next got=%h exp=52", bus.Data_out); end
        cycle(); bus.read_en_W = 0;
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL t5_empty got=%0h exp=1", bus.empty); end
    endtask

    task automatic test_misuse();
        bus.DRTS = 1; bus.RX = 32'h60; cycle(); bus.DRTS = 0; cycle();
        bus.read_en_N = 1; bus.read_en_S = 1;
        cycle();
        checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin failures++; $display("FAIL t6_onepop got count=%0d empty=%0h exp 0 1", bus.count, bus.empty); end
        bus.read_en_E = 1; bus.read_en_W = 1; bus.read_en_L = 1;
        cycle(); cycle();
        checks++; if (bus.count !== 3'd0 || bus.Data_out !== 32'h0) begin failures++; $display("FAIL t6_empty got count=%0d data=%h exp 0 0", bus.count, bus.Data_out); end
        clear_inputs();
        bus.DRTS = 1; bus.RX = 32'h61; cycle(); bus.DRTS = 0;
        checks++; if (bus.Data_out !== 32'h61 || bus.count !== 3'd1) begin failures++; $display("FAIL t6_after got data=%h count=%0d exp 61 1", bus.Data_out, bus.count); end
        cycle();
        bus.read_en_S = 1; cycle(); bus.read_en_S = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if (bus.DRTS && cts_m) bus.DRTS = 0;
            else if (!bus.DRTS && ($urandom_range(0, 1) == 1)) begin
                bus.DRTS = 1; bus.RX = $urandom;
            end
            bus.read_en_N = ($urandom_range(0, 5) == 0);
            bus.read_en_E = ($urandom_range(0, 5) == 0);
            bus.read_en_W = ($urandom_range(0, 5) == 0);
            bus.read_en_S = ($urandom_range(0, 5) == 0);
            bus.read_en_L = ($urandom_range(0, 9) == 0);
            cycle();
            checks++; if (bus.CTS !== cts_m) begin failures++; $display("FAIL rnd_cts got=%0h exp=%0h n=%0d", bus.CTS, cts_m, n); end
            checks++; if (bus.count !== exp_count()) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d n=%0d", bus.count, exp_count(), n); end
            checks++; if (bus.empty !== (mq.size() == 0)) begin failures++; $display("FAIL rnd_empty got=%0h n=%0d", bus.empty, n); end
            checks++; if (bus.full !== (mq.size() == DP)) begin failures++; $display("FAIL rnd_full got=%0h n=%0d", bus.full, n); end
            checks++; if (bus.Data_out !== exp_data()) begin failures++; $display("FAIL rnd_data got=%h exp=%h n=%0d", bus.Data_out, exp_data(), n); end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_wrap_order();
        test_simultaneous();
        test_misuse();
        apply_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
